// File: rtl/bsearch_ctrl.sv
// bsearch_ctrl: sequential binary-search controller for an external magnitude comparator.
//
// Drives a registered operand (guess) onto comparator input a, reads back the
// less/greater/equal flags for the unknown target on input b, and narrows the
// [lo, hi] window by one probe per clock until the target is hit or the window
// collapses at the range boundary.
//
// Optional feature macro: BSEARCH_FLAG_CHECK_EN
//   defined   -> a non-one-hot flag vector aborts the search with err=1
//   undefined -> err is tied 0; flag priority is equal > greater > less,
//                and an all-zero flag vector is treated as less
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a new search (sampled only in IDLE or DONE)
//   guess        registered comparator operand
//   cmp_less     comparator flag: guess < target
//   cmp_greater  comparator flag: guess > target
//   cmp_equal    comparator flag: guess == target
//   busy         high while searching
//   done         high while in DONE, held until the next start
//   found        valid with done: target located
//   err          valid with done: invalid flag combination seen
//   result       located value when found, else 0
//   steps        number of probes taken
module bsearch_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [WIDTH-1:0]            guess,
    input  logic                        cmp_less,
    input  logic                        cmp_greater,
    input  logic                        cmp_equal,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic                        err,
    output logic [WIDTH-1:0]            result,
    output logic [$clog2(WIDTH+2)-1:0]  steps
);

    localparam int unsigned SW = $clog2(WIDTH + 2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_W1 = (WIDTH + 1)'(1);
    localparam logic [SW-1:0]    ONE_S  = SW'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             bad_flags;

    // Midpoints of the shrunk window, kept one bit wider so lo+hi never wraps.
    logic [WIDTH:0] mid_dn;
    logic [WIDTH:0] mid_up;

    assign mid_dn = {1'b0, lo_q} + {1'b0, guess_q} - ONE_W1;
    assign mid_up = {1'b0, guess_q} + ONE_W1 + {1'b0, hi_q};

`ifdef BSEARCH_FLAG_CHECK_EN
    assign bad_flags = !$onehot({cmp_less, cmp_greater, cmp_equal});
`else
    // Without the check the flop below never sets, so err stays at 0.
    assign bad_flags = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        steps_d  = steps_q;
        found_d  = found_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = '1;
                    guess_d  = {1'b0, {(WIDTH-1){1'b1}}};
                    steps_d  = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = S_SEARCH;
                end
            end
            S_SEARCH: begin
                steps_d = steps_q + ONE_S;
                if (bad_flags) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (cmp_equal) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = S_DONE;
                end else if (cmp_greater) begin
                    // guess == lo means the window is exhausted downward.
                    if (guess_q == lo_q) begin
                        found_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        hi_d    = guess_q - ONE_W;
                        guess_d = mid_dn[WIDTH:1];
                    end
                end else begin
                    // cmp_less, or no flag at all.
                    if (guess_q == hi_q) begin
                        found_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        lo_d    = guess_q + ONE_W;
                        guess_d = mid_up[WIDTH:1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == S_SEARCH);
    assign done   = (state_q == S_DONE);
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule
